// File: rtl/fetch_unit.sv
// Instruction fetch front end: single-outstanding memory request, prefetch FIFO, redirect flush.
// Define FETCH_STATS_EN to add the o_fetch_cnt / o_drop_cnt statistics outputs.
module fetch_unit #(
  parameter int RW = 16,
  parameter int IW = 32,
  parameter int DEPTH = 2,
  parameter logic [RW-1:0] RESET_PC = {RW{1'b0}}
) (
  input  logic          i_clk,
  input  logic          i_rst,
  output logic          o_mem_req,
  output logic [RW-1:0] o_mem_addr,
  input  logic          i_mem_ack,
  input  logic [IW-1:0] i_mem_data,
  input  logic          i_redirect,
  input  logic [RW-1:0] i_redirect_pc,
  output logic          o_instr_valid,
  output logic [IW-1:0] o_instr,
  output logic [RW-1:0] o_instr_pc,
  input  logic          i_instr_ready
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]   o_fetch_cnt,
  output logic [15:0]   o_drop_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [RW-1:0] PC_ONE = {{(RW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_DROP = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] fetch_pc_q, fetch_pc_d;
  logic [RW-1:0] addr_q, addr_d;
  logic [CW-1:0] count_q, count_d, count_after_s;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [IW-1:0] instr_mem_q [DEPTH];
  logic [RW-1:0] pc_mem_q [DEPTH];
  logic          push_s, pop_s;

  // A request still live when acked is the only thing ever written into the FIFO.
  assign push_s = (state_q == ST_REQ) & i_mem_ack & ~i_redirect;
  assign pop_s  = (count_q != {CW{1'b0}}) & i_instr_ready;

  // State register and FIFO bookkeeping
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      count_q    <= {CW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      wr_ptr_q   <= {PW{1'b0}};
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // FIFO storage (contents are don't-care while invalid, so no reset)
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      instr_mem_q[wr_ptr_q] <= i_mem_data;
      pc_mem_q[wr_ptr_q]    <= addr_q;
    end
  end

  // FIFO occupancy and pointers; a redirect flushes regardless of push/pop
  always_comb begin
    count_after_s = count_q + CW'(push_s) - CW'(pop_s);
    count_d  = count_after_s;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (i_redirect) begin
      count_d  = {CW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      wr_ptr_d = {PW{1'b0}};
    end else begin
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (i_redirect) begin
          fetch_pc_d = i_redirect_pc;
        end else if (count_q < DEPTH_C) begin
          state_d = ST_REQ;
          addr_d  = fetch_pc_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (i_redirect) begin
          fetch_pc_d = i_redirect_pc;
          state_d    = i_mem_ack ? ST_IDLE : ST_DROP;
        end else if (i_mem_ack) begin
          fetch_pc_d = addr_q + PC_ONE;
          // Reissue back-to-back only if the slot is already guaranteed free.
          if (count_after_s < DEPTH_C) begin
            addr_d = addr_q + PC_ONE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_DROP: begin
        if (i_redirect) begin
          fetch_pc_d = i_redirect_pc;
        end else begin
          fetch_pc_d = fetch_pc_q;
        end
        // The stale ack ends the drop even if a new redirect lands the same cycle.
        if (i_mem_ack) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    o_mem_req     = (state_q != ST_IDLE);
    o_mem_addr    = addr_q;
    o_instr_valid = (count_q != {CW{1'b0}});
    o_instr       = instr_mem_q[rd_ptr_q];
    o_instr_pc    = pc_mem_q[rd_ptr_q];
  end

`ifdef FETCH_STATS_EN
  logic [15:0] fetch_cnt_q, drop_cnt_q;
  logic        drop_s;

  assign drop_s = i_mem_ack & (((state_q == ST_REQ) & i_redirect) | (state_q == ST_DROP));

  // Accepted/discarded instruction counters, wrapping at 16 bits
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_cnt_q <= 16'h0000;
      drop_cnt_q  <= 16'h0000;
    end else begin
      fetch_cnt_q <= fetch_cnt_q + {15'h0000, push_s};
      drop_cnt_q  <= drop_cnt_q + {15'h0000, drop_s};
    end
  end

  assign o_fetch_cnt = fetch_cnt_q;
  assign o_drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: transaction-level model of request addresses, FIFO contents
// and handshake rules; memory returns addr^0xA5A5A5A5 after a random delay.
module tb_fetch_unit;
  localparam int RW = 16;
  localparam int IW = 32;
  localparam int DEPTH = 2;
  localparam logic [RW-1:0] RESET_PC = 16'h0000;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          o_mem_req;
  logic [RW-1:0] o_mem_addr;
  logic          i_mem_ack = 1'b0;
  logic [IW-1:0] i_mem_data = 32'h0;
  logic          i_redirect = 1'b0;
  logic [RW-1:0] i_redirect_pc = 16'h0;
  logic          o_instr_valid;
  logic [IW-1:0] o_instr;
  logic [RW-1:0] o_instr_pc;
  logic          i_instr_ready = 1'b0;
`ifdef FETCH_STATS_EN
  logic [15:0]   o_fetch_cnt, o_drop_cnt;
`endif

  fetch_unit #(.RW(RW), .IW(IW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
    .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_instr_valid(o_instr_valid), .o_instr(o_instr), .o_instr_pc(o_instr_pc),
    .i_instr_ready(i_instr_ready)
`ifdef FETCH_STATS_EN
    , .o_fetch_cnt(o_fetch_cnt), .o_drop_cnt(o_drop_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [RW-1:0] pc; logic [IW-1:0] data; } ent_t;

  int vectors = 0;
  int errors = 0;

  ent_t          q[$];
  logic [RW-1:0] exp_fetch = RESET_PC;
  logic [RW-1:0] prev_addr = 16'h0;
  bit            live = 1'b0, prev_req = 1'b0, prev_ack = 1'b0, fired = 1'b0;
  int            age = 0, target = 1, idle_run = 0, fetched = 0, drops = 0;
  int            dly_min = 1, dly_max = 1, ready_pct = 100, redir_pct = 0, redir_mode = 0;
  logic [RW-1:0] redir_pc = 16'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: check what the DUT shows, drive the next inputs, advance the model.
  task automatic step();
    logic          req, valid, newreq, ack, redir, rdy;
    logic [RW-1:0] addr, rpc;
    logic [IW-1:0] data;
    @(negedge i_clk);
    req = o_mem_req; addr = o_mem_addr; valid = o_instr_valid;

    check_eq("instr_valid", 32'(valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check_eq("instr_pc", 32'(o_instr_pc), 32'(q[0].pc));
      check_eq("instr_data", o_instr, q[0].data);
    end
    if (prev_req && !prev_ack) begin
      check_eq("req_held", 32'(req), 32'd1);
      check_eq("addr_held", 32'(addr), 32'(prev_addr));
    end
    newreq = req && (!prev_req || prev_ack);
    if (newreq) begin
      check_eq("req_addr", 32'(addr), 32'(exp_fetch));
      check_eq("req_room", 32'(q.size() < DEPTH), 32'd1);
      age = 0; live = 1'b1;
      target = $urandom_range(dly_max, dly_min);
    end else if (req) begin
      age++;
    end
    if (!req && q.size() < DEPTH) idle_run++;
    else idle_run = 0;
    check_eq("issue_stall", 32'(idle_run <= 2), 32'd1);
`ifdef FETCH_STATS_EN
    check_eq("fetch_cnt", 32'(o_fetch_cnt), 32'(fetched[15:0]));
    check_eq("drop_cnt", 32'(o_drop_cnt), 32'(drops[15:0]));
`endif

    rdy = ($urandom_range(99, 0) < ready_pct);
    redir = 1'b0; rpc = redir_pc;
    if (redir_mode == 2 && newreq) begin
      redir = 1'b1; target = 3; fired = 1'b1; redir_mode = 0;
    end
    ack = req && (age >= target);
    if (redir_mode == 3 && ack) begin
      redir = 1'b1; fired = 1'b1; redir_mode = 0;
    end
    if (redir_mode == 1 && $urandom_range(99, 0) < redir_pct) begin
      redir = 1'b1;
      rpc = ($urandom_range(9, 0) == 0) ? 16'hFFFF : 16'($urandom);
    end
    data = ack ? ({16'h0000, addr} ^ 32'hA5A5A5A5) : 32'($urandom);
    i_instr_ready = rdy; i_mem_ack = ack; i_mem_data = data;
    i_redirect = redir; i_redirect_pc = rpc;

    if (redir) begin
      q.delete();
      exp_fetch = rpc;
      if (req && ack) drops++;
      live = 1'b0; idle_run = 0;
    end else begin
      if (valid && rdy) void'(q.pop_front());
      if (req && ack) begin
        if (live) begin
          q.push_back('{addr, data});
          exp_fetch = addr + 16'd1;
          fetched++;
        end else begin
          drops++;
        end
      end
    end
    prev_req = req; prev_ack = ack; prev_addr = addr;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1; i_mem_ack = 1'b0; i_redirect = 1'b0;
    @(negedge i_clk);
    check_eq("rst_req", 32'(o_mem_req), 32'd0);
    check_eq("rst_valid", 32'(o_instr_valid), 32'd0);
`ifdef FETCH_STATS_EN
    check_eq("rst_fetch_cnt", 32'(o_fetch_cnt), 32'd0);
    check_eq("rst_drop_cnt", 32'(o_drop_cnt), 32'd0);
`endif
    i_rst = 1'b0;
    q.delete(); exp_fetch = RESET_PC;
    prev_req = 1'b0; prev_ack = 1'b0; live = 1'b0;
    idle_run = 0; fetched = 0; drops = 0;
    @(negedge i_clk);
    check_eq("first_req", 32'(o_mem_req), 32'd1);
    check_eq("first_addr", 32'(o_mem_addr), 32'(RESET_PC));
  endtask

  task automatic directed_redirect(input int mode, input logic [RW-1:0] pc, input string tag);
    fired = 1'b0; redir_mode = mode; redir_pc = pc;
    run(12);
    check_eq(tag, 32'(fired), 32'd1);
    redir_mode = 0;
  endtask

  initial begin
    repeat (2) @(negedge i_clk);
    do_reset();
    ready_pct = 100; dly_min = 1; dly_max = 1;
    run(20);
    ready_pct = 0;
    run(15);
    ready_pct = 100;
    run(10);
    directed_redirect(2, 16'h0040, "redir_stale_fired");
    directed_redirect(3, 16'h0100, "redir_on_ack_fired");
    directed_redirect(2, 16'hFFFE, "redir_wrap_fired");
    run(6);
    dly_min = 3; dly_max = 3;
    run(3);
    check_eq("pre_rst_req", 32'(o_mem_req), 32'd1);
    do_reset();
    dly_min = 1; dly_max = 3;
    redir_mode = 1; redir_pct = 4;
    for (int b = 0; b < 15; b++) begin
      ready_pct = $urandom_range(100, 0);
      run(100);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end. Consumes the program-counter stream and drives the instruction memory port with a single-outstanding-request handshake.
- Buffers returned instruction words in a small prefetch FIFO and presents them to decode with a valid/ready handshake.
- Redirects (jump, bus load, IRQ vector) flush the FIFO and restart fetch at the new address. Stale in-flight data is discarded.

Parameters:
- RW, 16, address/PC width in bits.
- IW, 32, instruction word width in bits.
- DEPTH, 2, prefetch FIFO entries (power of two, ≥2).
- RESET_PC, 0, fetch address after reset.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  synchronous, active-high reset.
- o_mem_req  output  1  memory request; held until ack.
- o_mem_addr  output  RW  request word address; stable while o_mem_req=1.
- i_mem_ack  input  1  one-cycle pulse; i_mem_data valid this cycle.
- i_mem_data  input  IW  returned instruction word.
- i_redirect  input  1  one-cycle pulse: flush and restart at i_redirect_pc.
- i_redirect_pc  input  RW  new fetch address.
- o_instr_valid  output  1  FIFO head valid.
- o_instr  output  IW  FIFO head instruction.
- o_instr_pc  output  RW  address of FIFO head instruction.
- i_instr_ready  input  1  decode accepts head when valid&ready.

Behaviour:
- Reset (i_rst sampled at posedge):
  - o_mem_req=0, o_instr_valid=0, FIFO empty, internal fetch_pc=RESET_PC, state=IDLE.
  - Any outstanding memory transaction is abandoned. The memory side is reset concurrently.
- Internal state:
  - fetch_pc = next address to request.
  - count = FIFO occupancy.
  - inflight = 1 while o_mem_req=1.
- States:
  - IDLE:
    - If count+inflight < DEPTH and no redirect this cycle: o_mem_req<=1, o_mem_addr<=fetch_pc, go REQ.
    - Request issues the cycle after the condition holds. First request after reset deasserts is at RESET_PC one cycle later.
  - REQ: o_mem_req=1, address held.
    - On i_mem_ack without redirect:
      - Push {i_mem_data, o_mem_addr} into FIFO.
      - fetch_pc <= o_mem_addr+1, wrapping modulo 2^RW (0xFFFF -> 0x0000).
      - If space remains after this push and the same-cycle pop, re-issue back-to-back next cycle at the new address. Else deassert and go IDLE.
      - Maximum throughput: one instruction per 2 cycles with a 1-cycle-ack memory. Ack in the same cycle as request assertion is not allowed; ack earliest the cycle after.
  - DROP: o_mem_req stays 1 with the stale address until i_mem_ack.
    - Ack data is discarded, not pushed.
    - Then go IDLE, and fetch resumes at fetch_pc (the redirect target).
- Redirect (i_redirect=1), takes priority over everything else:
  - FIFO flushed (count<=0, o_instr_valid<=0 next cycle).
  - fetch_pc <=i_redirect_pc.
  - A head pop in the same cycle is still considered accepted by decode, but no new entry becomes visible.
  - If REQ without ack this cycle: go DROP.
  - If REQ with ack this cycle: discard the data, go IDLE.
  - If DROP: stay DROP, update fetch_pc.
  - Back-to-back redirects: last one wins.
- FIFO:
  - Push and pop in the same cycle with count=DEPTH: this is allowed only because issue reserved space; count is unchanged.
  - Pop when empty is ignored.
  - o_instr/o_instr_pc reflect the head combinationally from storage. Contents are don't-care when invalid.
- o_mem_req never deasserts before i_mem_ack, including across redirects.
- Overflow is impossible: issue requires count+inflight<DEPTH.

Optional Feature:
- FETCH_STATS_EN defined:
  - Adds output o_fetch_cnt [15:0], which increments per accepted (pushed) instruction.
  - Adds output o_drop_cnt [15:0], which increments per discarded ack (DROP or redirect-with-ack).
  - Both counters wrap at 0xFFFF->0 and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, memory acks 1 cycle after each request with data=addr^0xA5A5A5A5, ready=1 -> requests at 0,1,2,...; o_instr_pc sequence 0,1,2; o_instr=0xA5A5A5A5,0xA5A5A5A4,...
- Decode ready=0, DEPTH=2 -> exactly 2 requests (addr 0,1), o_mem_req then stays 0. Raise ready -> a new request at addr 2 the cycle after the first pop.
- Redirect to 0x0040 while request at 0x0003 is unacked, ack 3 cycles later -> o_mem_req held at 0x0003 until ack, data not delivered, next request at 0x0040, first o_instr_pc=0x0040.
- Redirect coincident with ack of 0x0005 -> ack data dropped, FIFO empty next cycle, next request at redirect target.
- fetch_pc at 0xFFFF acked -> next request address 0x0000.
- i_rst asserted while REQ outstanding -> next cycle o_mem_req=0, o_instr_valid=0; after release, request at RESET_PC. With FETCH_STATS_EN: o_fetch_cnt/o_drop_cnt=0 after reset, o_drop_cnt=1 after the drop scenario.
